// File: rtl/rdma_tx_pkt_mux_if.sv
// AXI4-Stream bundle used on every port of the RDMA TX packet mux.
// master drives data/valid and samples ready; slave is the mirror image.
interface rdma_tx_pkt_mux_if #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tkeep, output tlast, output tuser, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tlast, input tuser, input tvalid, output tready);
endinterface

// File: rtl/rdma_tx_pkt_mux.sv
// RDMA TX packet mux: merges the RoCE (ERNIC) and non-RoCE (host stack) TX
// streams into one registered AXI4-Stream toward the CMAC TX port.
// Arbitration is per packet; a packet, once started, owns the output until
// its tlast beat is accepted.
// Optional build macro RDMA_TX_MUX_STATS_EN adds packet and stall counters.
module rdma_tx_pkt_mux #(
  parameter int DATA_WIDTH    = 512,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int USER_WIDTH    = 1,
  parameter int ROCE_PRIORITY = 0
) (
  input logic               clk,
  input logic               rst,
  rdma_tx_pkt_mux_if.slave  roce_s_axis,
  rdma_tx_pkt_mux_if.slave  non_roce_s_axis,
  rdma_tx_pkt_mux_if.master m_axis
`ifdef RDMA_TX_MUX_STATS_EN
  ,
  output logic [31:0]       stat_roce_pkts,
  output logic [31:0]       stat_non_roce_pkts,
  output logic [31:0]       stat_roce_stall
`endif
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ROCE     = 2'd1,
    S_NON_ROCE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  rr_non_q, rr_non_d;   // 1: non-RoCE wins the next tie
  logic                  tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
  logic                  tlast_q, tlast_d;
  logic [USER_WIDTH-1:0] tuser_q, tuser_d;

  logic out_free;
  logic grant_roce, grant_non;
  logic acc_roce, acc_non;

  // Grant: locked input while mid-packet, otherwise decided from current requests.
  always_comb begin
    grant_roce = 1'b0;
    grant_non  = 1'b0;
    case (state_q)
      S_ROCE:     grant_roce = 1'b1;
      S_NON_ROCE: grant_non  = 1'b1;
      default: begin
        if (roce_s_axis.tvalid && non_roce_s_axis.tvalid) begin
          if ((ROCE_PRIORITY != 0) || !rr_non_q) grant_roce = 1'b1;
          else                                   grant_non  = 1'b1;
        end else begin
          grant_roce = roce_s_axis.tvalid;
          grant_non  = non_roce_s_axis.tvalid;
        end
      end
    endcase
  end

  // The output register can take a beat when empty or draining this cycle.
  assign out_free               = !tvalid_q || m_axis.tready;
  assign roce_s_axis.tready     = !rst && out_free && grant_roce;
  assign non_roce_s_axis.tready = !rst && out_free && grant_non;
  assign acc_roce               = roce_s_axis.tvalid && roce_s_axis.tready;
  assign acc_non                = non_roce_s_axis.tvalid && non_roce_s_axis.tready;

  // Next state, round-robin pointer and output register load/drain.
  always_comb begin
    state_d  = (state_q == S_ROCE || state_q == S_NON_ROCE) ? state_q : S_IDLE;
    rr_non_d = rr_non_q;
    tvalid_d = tvalid_q && !m_axis.tready;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;
    if (acc_roce) begin
      tvalid_d = 1'b1;
      tdata_d  = roce_s_axis.tdata;
      tkeep_d  = roce_s_axis.tkeep;
      tlast_d  = roce_s_axis.tlast;
      tuser_d  = roce_s_axis.tuser;
      if (roce_s_axis.tlast) begin
        state_d  = S_IDLE;
        rr_non_d = 1'b1;
      end else begin
        state_d  = S_ROCE;
      end
    end else if (acc_non) begin
      tvalid_d = 1'b1;
      tdata_d  = non_roce_s_axis.tdata;
      tkeep_d  = non_roce_s_axis.tkeep;
      tlast_d  = non_roce_s_axis.tlast;
      tuser_d  = non_roce_s_axis.tuser;
      if (non_roce_s_axis.tlast) begin
        state_d  = S_IDLE;
        rr_non_d = 1'b0;
      end else begin
        state_d  = S_NON_ROCE;
      end
    end
  end

  // State, pointer and output register; reset abandons any partial packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_non_q <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tuser_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_non_q <= rr_non_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tkeep  = tkeep_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tuser  = tuser_q;

`ifdef RDMA_TX_MUX_STATS_EN
  logic [31:0] stat_roce_pkts_q, stat_roce_pkts_d;
  logic [31:0] stat_non_roce_pkts_q, stat_non_roce_pkts_d;
  logic [31:0] stat_roce_stall_q, stat_roce_stall_d;

  // Packet counters wrap; the RoCE stall counter saturates.
  always_comb begin
    stat_roce_pkts_d     = stat_roce_pkts_q;
    stat_non_roce_pkts_d = stat_non_roce_pkts_q;
    stat_roce_stall_d    = stat_roce_stall_q;
    if (acc_roce && roce_s_axis.tlast)        stat_roce_pkts_d     = stat_roce_pkts_q + 32'd1;
    if (acc_non && non_roce_s_axis.tlast)     stat_non_roce_pkts_d = stat_non_roce_pkts_q + 32'd1;
    if (roce_s_axis.tvalid && !roce_s_axis.tready && (stat_roce_stall_q != 32'hFFFF_FFFF))
      stat_roce_stall_d = stat_roce_stall_q + 32'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_roce_pkts_q     <= '0;
      stat_non_roce_pkts_q <= '0;
      stat_roce_stall_q    <= '0;
    end else begin
      stat_roce_pkts_q     <= stat_roce_pkts_d;
      stat_non_roce_pkts_q <= stat_non_roce_pkts_d;
      stat_roce_stall_q    <= stat_roce_stall_d;
    end
  end

  assign stat_roce_pkts     = stat_roce_pkts_q;
  assign stat_non_roce_pkts = stat_non_roce_pkts_q;
  assign stat_roce_stall    = stat_roce_stall_q;
`endif

endmodule

// File: tb/tb_rdma_tx_pkt_mux.sv
// Bench for rdma_tx_pkt_mux: packet-level reference model plus per-source
// scoreboard, driven by directed packet sequences.
module tb_rdma_tx_pkt_mux;
  localparam int DW   = 512;
  localparam int KW   = DW / 8;
  localparam int UW   = 1;
  localparam int PRIO = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rdma_tx_pkt_mux_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) roce_if ();
  rdma_tx_pkt_mux_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) non_if ();
  rdma_tx_pkt_mux_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) m_if ();

`ifdef RDMA_TX_MUX_STATS_EN
  logic [31:0] st_rp, st_np, st_rs;
  logic [31:0] m_rp, m_np, m_rs;
`endif

  rdma_tx_pkt_mux #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .ROCE_PRIORITY(PRIO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .roce_s_axis     (roce_if),
    .non_roce_s_axis (non_if),
    .m_axis          (m_if)
`ifdef RDMA_TX_MUX_STATS_EN
    ,
    .stat_roce_pkts     (st_rp),
    .stat_non_roce_pkts (st_np),
    .stat_roce_stall    (st_rs)
`endif
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  beat_t q_roce[$];
  beat_t q_non[$];
  beat_t exp_roce[$];
  beat_t exp_non[$];
  bit    out_src_log[$];
  int    out_cyc_log[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pid = 0;
  int mtr_pct = 100;
  int gap_pct = 0;
  bit rst_req = 1'b1;

  // reference model: which source owns the packet in flight, tie pointer, output register
  int    m_lock = 0;       // 0 none, 1 RoCE, 2 non-RoCE
  bit    m_rr_non = 1'b0;
  bit    m_ov = 1'b0;
  beat_t m_ob;
  bit    started = 1'b0;
  bit    in_pkt = 1'b0;
  bit    cur_src = 1'b0;

  // what was presented before the last rising edge
  bit    r_rst = 1'b0, r_rv = 1'b0, r_nv = 1'b0, r_rr = 1'b0, r_nr = 1'b0, r_mtr = 1'b0;
  beat_t r_rb, r_nb;
  logic [DW-1:0] prev_data;
  bit    prev_stall = 1'b0;

  function automatic beat_t zero_beat();
    beat_t b;
    b.data = '0; b.keep = '0; b.last = 1'b0; b.user = '0;
    return b;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int log_bits();
    int v = 0;
    for (int i = 0; i < out_src_log.size(); i++) v |= int'(out_src_log[i]) << i;
    return v;
  endfunction

  function automatic int span();
    if (out_cyc_log.size() == 0) return -1;
    return out_cyc_log[out_cyc_log.size()-1] - out_cyc_log[0];
  endfunction

  // per-cycle model update, drive and compare
  initial begin
    bit    mtr, rv, nv, gr, gn, er, en, hold_r, hold_n, src;
    beat_t hb, nb, sb;
    m_ob = zero_beat();
    forever begin
      @(negedge clk);
      if (r_rst) begin
        m_lock = 0; m_rr_non = 1'b0; m_ov = 1'b0; m_ob = zero_beat();
        exp_roce.delete(); exp_non.delete();
        started = 1'b1; in_pkt = 1'b0;
`ifdef RDMA_TX_MUX_STATS_EN
        m_rp = 0; m_np = 0; m_rs = 0;
`endif
      end else begin
        if (r_rv && r_rr) begin
          m_ob = r_rb; m_ov = 1'b1;
          m_lock = r_rb.last ? 0 : 1;
          if (r_rb.last) m_rr_non = 1'b1;
          if (q_roce.size() > 0) void'(q_roce.pop_front());
`ifdef RDMA_TX_MUX_STATS_EN
          if (r_rb.last) m_rp++;
`endif
        end else if (r_nv && r_nr) begin
          m_ob = r_nb; m_ov = 1'b1;
          m_lock = r_nb.last ? 0 : 2;
          if (r_nb.last) m_rr_non = 1'b0;
          if (q_non.size() > 0) void'(q_non.pop_front());
`ifdef RDMA_TX_MUX_STATS_EN
          if (r_nb.last) m_np++;
`endif
        end else if (r_mtr) begin
          m_ov = 1'b0;
        end
`ifdef RDMA_TX_MUX_STATS_EN
        if (r_rv && !r_rr) m_rs++;
`endif
      end

      if (started) begin
        chk("m_tvalid", DW'(m_if.tvalid), DW'(m_ov));
        chk("m_tdata", m_if.tdata, m_ob.data);
        chk("m_tkeep", DW'(m_if.tkeep), DW'(m_ob.keep));
        chk("m_tlast", DW'(m_if.tlast), DW'(m_ob.last));
        chk("m_tuser", DW'(m_if.tuser), DW'(m_ob.user));
        if (prev_stall) chk("hold_tdata", m_if.tdata, prev_data);
`ifdef RDMA_TX_MUX_STATS_EN
        chk("stat_roce_pkts", DW'(st_rp), DW'(m_rp));
        chk("stat_non_roce_pkts", DW'(st_np), DW'(m_np));
        chk("stat_roce_stall", DW'(st_rs), DW'(m_rs));
`endif
      end

      rst = rst_req;
      mtr = ($urandom_range(99) < mtr_pct);
      m_if.tready = mtr;
      hold_r = r_rv && !r_rr && !r_rst;
      hold_n = r_nv && !r_nr && !r_rst;
      rv = (q_roce.size() > 0) && (hold_r || ($urandom_range(99) >= gap_pct));
      nv = (q_non.size() > 0) && (hold_n || ($urandom_range(99) >= gap_pct));
      hb = rv ? q_roce[0] : zero_beat();
      nb = nv ? q_non[0] : zero_beat();
      roce_if.tvalid = rv; roce_if.tdata = hb.data; roce_if.tkeep = hb.keep;
      roce_if.tlast = hb.last; roce_if.tuser = hb.user;
      non_if.tvalid = nv; non_if.tdata = nb.data; non_if.tkeep = nb.keep;
      non_if.tlast = nb.last; non_if.tuser = nb.user;

      #1;
      gr = 1'b0; gn = 1'b0;
      if (m_lock == 1) gr = 1'b1;
      else if (m_lock == 2) gn = 1'b1;
      else if (rv && nv) begin
        if (PRIO != 0 || !m_rr_non) gr = 1'b1; else gn = 1'b1;
      end else begin
        gr = rv; gn = nv;
      end
      er = !rst && (!m_ov || mtr) && gr;
      en = !rst && (!m_ov || mtr) && gn;
      chk("roce_tready", DW'(roce_if.tready), DW'(er));
      chk("non_roce_tready", DW'(non_if.tready), DW'(en));

      if (started && !rst && m_if.tvalid && mtr) begin
        src = m_if.tdata[15];
        if (in_pkt) chk("no_interleave", DW'(src), DW'(cur_src));
        if ((src ? exp_non.size() : exp_roce.size()) == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL scoreboard: got unexpected beat tag %0h expected none", m_if.tdata[15:0]);
        end else begin
          sb = src ? exp_non.pop_front() : exp_roce.pop_front();
          chk("sb_tdata", m_if.tdata, sb.data);
        end
        cur_src = src;
        in_pkt = !m_if.tlast;
        out_cyc_log.push_back(cyc);
        if (m_if.tlast) out_src_log.push_back(src);
      end
      if (rv && er) exp_roce.push_back(hb);
      if (nv && en) exp_non.push_back(nb);

      r_rst = rst; r_rv = rv; r_nv = nv; r_rr = er; r_nr = en; r_mtr = mtr;
      r_rb = hb; r_nb = nb;
      prev_stall = started && !rst && m_if.tvalid && !mtr;
      prev_data = m_if.tdata;
      cyc++;
    end
  end

  task automatic push_pkt(input int src, input int nb, input logic [KW-1:0] lkeep);
    for (int i = 0; i < nb; i++) begin
      beat_t b;
      for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom;
      b.data[15:0] = {src[0], pid[6:0], i[7:0]};
      b.last = (i == nb - 1);
      b.keep = b.last ? lkeep : {KW{1'b1}};
      b.user = UW'($urandom);
      if (src == 0) q_roce.push_back(b); else q_non.push_back(b);
    end
    pid++;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(q_roce.size() == 0 && q_non.size() == 0 && exp_roce.size() == 0 &&
             exp_non.size() == 0 && !m_ov) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d cycles expected fewer than %0d", n, budget);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    rst_req = 1'b1;
    q_roce.delete(); q_non.delete();
    @(posedge clk);
    rst_req = 1'b0;
  endtask

  task automatic clear_logs();
    out_src_log.delete();
    out_cyc_log.delete();
  endtask

  initial begin
    int total;
    repeat (3) @(posedge clk);
    rst_req = 1'b0;
    @(posedge clk);

    // single RoCE 3-beat packet, partial keep on the last beat
    clear_logs();
    push_pkt(0, 3, 64'h0000_0000_0000_FFFF);
    wait_idle(200);
    chk("t1_pkts", DW'(out_src_log.size()), DW'(1));
    chk("t1_src", DW'(log_bits()), DW'(0));
    chk("t1_beats", DW'(out_cyc_log.size()), DW'(3));
    chk("t1_span", DW'(span()), DW'(2));

    // contention from a fresh pointer: two 2-beat packets per source
    do_reset();
    @(posedge clk);
    clear_logs();
    push_pkt(0, 2, '1); push_pkt(1, 2, '1); push_pkt(0, 2, '1); push_pkt(1, 2, '1);
    wait_idle(400);
    chk("t2_pkts", DW'(out_src_log.size()), DW'(4));
    chk("t2_order", DW'(log_bits()), DW'((PRIO != 0) ? 4'b1100 : 4'b1010));
    chk("t2_span", DW'(span()), DW'(7));

    // RoCE shows up while a non-RoCE packet holds the output
    clear_logs();
    push_pkt(1, 4, '1);
    @(posedge clk); @(posedge clk);
    push_pkt(0, 2, '1);
    wait_idle(400);
    chk("t3_order", DW'(log_bits()), DW'(1));
    chk("t3_span", DW'(span()), DW'(5));

    // back-to-back single-beat non-RoCE packets
    clear_logs();
    for (int i = 0; i < 5; i++) push_pkt(1, 1, KW'({$urandom, $urandom}));
    wait_idle(200);
    chk("t5_pkts", DW'(out_src_log.size()), DW'(5));
    chk("t5_span", DW'(span()), DW'(4));

    // random backpressure and request gaps over 100 mixed packets
    clear_logs();
    mtr_pct = 50; gap_pct = 20; total = 0;
    for (int i = 0; i < 100; i++) begin
      int s = int'($urandom_range(1));
      int n = int'($urandom_range(16, 1));
      push_pkt(s, n, KW'({$urandom, $urandom}));
      total += n;
    end
    wait_idle(20000);
    chk("t4_beats", DW'(out_cyc_log.size()), DW'(total));
    chk("t4_pkts", DW'(out_src_log.size()), DW'(100));
    mtr_pct = 100; gap_pct = 0;

    // reset during beat 2 of a 4-beat non-RoCE packet
    clear_logs();
    @(posedge clk);
    push_pkt(1, 4, '1);
    @(posedge clk); @(posedge clk);
    rst_req = 1'b1;
    q_roce.delete(); q_non.delete();
    @(posedge clk);
    rst_req = 1'b0;
    @(negedge clk);
    #2;
    chk("t6_tvalid", DW'(m_if.tvalid), DW'(0));
    chk("t6_roce_tready", DW'(roce_if.tready), DW'(0));
    chk("t6_non_tready", DW'(non_if.tready), DW'(0));
`ifdef RDMA_TX_MUX_STATS_EN
    chk("t6_stat_rp", DW'(st_rp), DW'(0));
    chk("t6_stat_np", DW'(st_np), DW'(0));
    chk("t6_stat_rs", DW'(st_rs), DW'(0));
`endif
    clear_logs();
    @(posedge clk);
    push_pkt(0, 2, '1);
    wait_idle(200);
    chk("t6_after_pkts", DW'(out_src_log.size()), DW'(1));
    chk("t6_after_src", DW'(log_bits()), DW'(0));

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected summary before time limit");
    $fatal(1, "watchdog");
  end
endmodule
